// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier for all multiply opcodes.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIXUP = 2'd2, S_DONE = 2'd3} state_t;

    localparam logic [XLEN-1:0]   ZERO_C = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONE_C  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ONES_C = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MIN_C  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE2_C = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(XLEN - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, result_q;
    logic [2:0]        funct3_q;
    logic              neg_q, rem_neg_q, busy_q, done_q;
    logic [4:0]        rd_q, rd_out_q;

    logic            is_div_s, a_sgn_s, b_sgn_s, neg_a_s, neg_b_s, special_s;
    logic [XLEN-1:0] mag_a_s, mag_b_s, special_res_s;

    // Operand decode: signedness, magnitudes and the cases that need no iteration
    always_comb begin
        is_div_s = funct3[2];
        case (funct3)
            3'b001:         begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
            3'b010:         begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
            3'b100, 3'b110: begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
            default:        begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
        endcase
        neg_a_s = a_sgn_s & op_a[XLEN-1];
        neg_b_s = b_sgn_s & op_b[XLEN-1];
        mag_a_s = neg_a_s ? (~op_a + ONE_C) : op_a;
        mag_b_s = neg_b_s ? (~op_b + ONE_C) : op_b;
        if (is_div_s && (op_b == ZERO_C)) begin
            special_s     = 1'b1;
            special_res_s = funct3[1] ? op_a : ONES_C;
        end else if (is_div_s && !funct3[0] && (op_a == MIN_C) && (op_b == ONES_C)) begin
            special_s     = 1'b1;
            special_res_s = funct3[1] ? ZERO_C : MIN_C;
        end else begin
            special_s     = 1'b0;
            special_res_s = ZERO_C;
        end
    end

    logic [XLEN:0] sum_s, shifted_s, diff_s;

    // One iteration: acc holds {partial product | remainder, multiplier | dividend-quotient}
    always_comb begin
        sum_s     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        shifted_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff_s    = shifted_s - {1'b0, opnd_q};
        if (funct3_q[2]) begin
            if (!diff_s[XLEN]) begin
                acc_d = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {shifted_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = {sum_s, acc_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, fix_res_s;

    // Sign fixup and result selection once the magnitude loop has finished
    always_comb begin
        prod_s = neg_q ? (~acc_q + ONE2_C) : acc_q;
        quot_s = neg_q ? (~acc_q[XLEN-1:0] + ONE_C) : acc_q[XLEN-1:0];
        rem_s  = rem_neg_q ? (~acc_q[2*XLEN-1:XLEN] + ONE_C) : acc_q[2*XLEN-1:XLEN];
        case (funct3_q)
            3'b000:                 fix_res_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res_s = quot_s;
            default:                fix_res_s = rem_s;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fa_s, fb_s, fast_prod_s;
    logic [XLEN-1:0]          fast_res_s;

    // Single-cycle product with operands sign- or zero-extended per opcode
    always_comb begin
        fa_s        = {{(XLEN+2){neg_a_s}}, op_a};
        fb_s        = {{(XLEN+2){neg_b_s}}, op_b};
        fast_prod_s = fa_s * fb_s;
        if (funct3 == 3'b000) begin
            fast_res_s = fast_prod_s[XLEN-1:0];
        end else begin
            fast_res_s = fast_prod_s[2*XLEN-1:XLEN];
        end
    end
`endif

    // Control FSM with registered outputs; flush abandons the op but keeps the last result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {(2*XLEN){1'b0}};
            opnd_q    <= ZERO_C;
            result_q  <= ZERO_C;
            funct3_q  <= 3'b000;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 5'd0;
            rd_out_q  <= 5'd0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        funct3_q <= funct3;
                        rd_q     <= rd_in;
                        cnt_q    <= {CNT_W{1'b0}};
                        busy_q   <= 1'b1;
                        if (special_s) begin
                            result_q <= special_res_s;
                            rd_out_q <= rd_in;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div_s) begin
                            result_q <= fast_res_s;
                            rd_out_q <= rd_in;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
`endif
                        else begin
                            acc_q     <= {ZERO_C, (is_div_s ? mag_a_s : mag_b_s)};
                            opnd_q    <= is_div_s ? mag_b_s : mag_a_s;
                            neg_q     <= neg_a_s ^ neg_b_s;
                            rem_neg_q <= neg_a_s;
                            state_q   <= S_CALC;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_C) begin
                        state_q <= S_FIXUP;
                    end else begin
                        state_q <= S_CALC;
                    end
                end
                S_FIXUP: begin
                    result_q <= fix_res_s;
                    rd_out_q <= rd_q;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table plus flush/reset/back-to-back sequences.
module tb_muldiv_unit;
    logic        clk, rst_n, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result;
    logic [4:0]  rd_in, rd_out;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 0;
`else
    localparam int ML = 33;
`endif

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   edges;
        logic busy_bad;
        wait_idle();
        funct3 = v.f; op_a = v.a; op_b = v.b; rd_in = v.rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        funct3 = 3'b111; op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0003; rd_in = 5'd31;
        edges = 0; busy_bad = 1'b0;
        while (!done && edges < 100) begin
            if (!busy) busy_bad = 1'b1;
            @(posedge clk); #1; edges++;
        end
        chk($sformatf("v%0d_result", idx), result, v.exp);
        chk($sformatf("v%0d_rd_out", idx), {27'd0, rd_out}, {27'd0, v.rd});
        chk($sformatf("v%0d_latency", idx), 32'(edges), 32'(v.lat));
        chk($sformatf("v%0d_busy", idx), {31'd0, busy_bad}, 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   ndone;
        logic bad;
        logic b34, b35;
        logic [31:0] prev_res;
        logic [4:0]  prev_rd;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, ML};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, ML};
        vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, ML};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4,  32'hFFFF_FFFF, ML};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         5'd5,  32'd14,        33};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         5'd5,  32'd2,         33};
        vecs[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h8000_0000, 0};
        vecs[9]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 0};
        vecs[10] = '{3'b101, 32'd9,         32'd0,         5'd8,  32'hFFFF_FFFF, 0};
        vecs[11] = '{3'b111, 32'd9,         32'd0,         5'd9,  32'd9,         0};
        vecs[12] = '{3'b000, 32'd6,         32'd7,         5'd10, 32'd42,        ML};
        vecs[13] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000, ML};
        vecs[14] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 5'd12, 32'h2345_6780, ML};
        vecs[15] = '{3'b100, 32'd100,       32'hFFFF_FFF9, 5'd13, 32'hFFFF_FFF2, 33};
        vecs[16] = '{3'b110, 32'hFFFF_FF9C, 32'd7,         5'd14, 32'hFFFF_FFFE, 33};
        vecs[17] = '{3'b010, 32'd2,         32'hFFFF_FFFF, 5'd15, 32'h0000_0001, ML};
        vecs[18] = '{3'b100, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 0};
        vecs[19] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         5'd17, 32'hFFFF_FFFB, 0};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        funct3 = 3'b000; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
        #1;
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd_out", {27'd0, rd_out}, 32'd0);
        #20;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) run_vec(vecs[i], i);
        prev_res = vecs[19].exp;
        prev_rd  = vecs[19].rd;

        // flush during a divide at cycle 10
        wait_idle();
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd20; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) bad = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush_no_done", {31'd0, bad}, 32'd0);
        chk("flush_result",  result, prev_res);
        chk("flush_rd_out",  {27'd0, rd_out}, {27'd0, prev_rd});

        // flush and start together in IDLE: the op is dropped
        funct3 = 3'b101; op_a = 32'd9; op_b = 32'd0; rd_in = 5'd21; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        chk("flushstart_busy", {31'd0, busy}, 32'd0);
        chk("flushstart_done", {31'd0, done}, 32'd0);
        chk("flushstart_result", result, prev_res);

        // asynchronous reset in the middle of a multiply
        funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd22; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",   {31'd0, busy}, 32'd0);
        chk("rst_mid_done",   {31'd0, done}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) bad = 1'b1;
        end
        chk("rst_mid_no_done", {31'd0, bad}, 32'd0);

        // start held high: one op per IDLE visit, next accepted the cycle after done
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3; start = 1'b1;
        ndone = 0; b34 = 1'b1; b35 = 1'b0;
        for (int e = 0; e < 70; e++) begin
            @(posedge clk); #1;
            if (e == 69) start = 1'b0;
            if (done) ndone++;
            if (e == 34) b34 = busy;
            if (e == 35) b35 = busy;
        end
        chk("b2b_done_count", 32'(ndone), 32'd2);
        chk("b2b_idle_gap",   {31'd0, b34}, 32'd0);
        chk("b2b_restart",    {31'd0, b35}, 32'd1);
        chk("b2b_result",     result, 32'd14);
        chk("b2b_rd_out",     {27'd0, rd_out}, 32'd3);
        @(posedge clk); #1;
        chk("b2b_no_third",   {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
